// File: rtl/dlx_pipe_pkg.sv
// Shared types and constants for the DLX operand-bypass controller.
// Select encodings match the ALU input mux: IN0 regfile, IN1 EX/MEM, IN2 MEM/WB.
package dlx_pipe_pkg;

    localparam int RW_DEF = 5;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic              v;
        logic [RW_DEF-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

endpackage

// File: rtl/dlx_fwd_sel.sv
// Per-source bypass select: picks the nearest in-flight producer of one operand.
module dlx_fwd_sel
    import dlx_pipe_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic          i_use,
    input  logic [RW-1:0] i_src,
    input  logic          i_ex_v,
    input  logic          i_ex_we,
    input  logic [RW-1:0] i_ex_rd,
    input  logic          i_mem_v,
    input  logic          i_mem_we,
    input  logic [RW-1:0] i_mem_rd,
    output logic [1:0]    o_sel
);

    logic w_live;

    // r0 is hard-wired zero, so it is never a bypass candidate.
    assign w_live = i_use & (i_src != '0);

    always_comb begin
        o_sel = SEL_RF;
        if (w_live && i_ex_v && i_ex_we && (i_ex_rd == i_src)) begin
            o_sel = SEL_EXMEM;
        end else if (w_live && i_mem_v && i_mem_we && (i_mem_rd == i_src)) begin
            o_sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/dlx_fwd_ctrl.sv
// DLX operand-bypass controller: tracks EX/MEM destinations, registers ALU mux
// selects for the instruction entering EX, and requests load-use stalls.
module dlx_fwd_ctrl
    import dlx_pipe_pkg::*;
#(
    parameter int RW = RW_DEF,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_hold,
    input  logic          i_id_valid,
    input  logic [RW-1:0] i_id_rs1,
    input  logic [RW-1:0] i_id_rs2,
    input  logic          i_id_use1,
    input  logic          i_id_use2,
    input  logic [RW-1:0] i_id_rd,
    input  logic          i_id_we,
    input  logic          i_id_load,
    output logic          o_sa0,
    output logic          o_sa1,
    output logic          o_sb0,
    output logic          o_sb1,
    output logic          o_haz_stall,
    output logic [CW-1:0] o_stall_cnt
);

    slot_t         r_ex;
    logic          r_mem_v;
    logic [RW-1:0] r_mem_rd;
    logic          r_mem_we;
    logic [1:0]    r_sa;
    logic [1:0]    r_sb;
    logic [CW-1:0] r_stall_cnt;

    logic [1:0]    w_sel_a;
    logic [1:0]    w_sel_b;
    logic          w_hit1;
    logic          w_hit2;
    logic          w_haz;

    assign w_hit1 = i_id_use1 & (i_id_rs1 == r_ex.rd);
    assign w_hit2 = i_id_use2 & (i_id_rs2 == r_ex.rd);
    assign w_haz  = i_id_valid & r_ex.v & r_ex.we & r_ex.ld & (w_hit1 | w_hit2);

    dlx_fwd_sel #(.RW(RW)) u_sel_a (
        .i_use    (i_id_valid & i_id_use1),
        .i_src    (i_id_rs1),
        .i_ex_v   (r_ex.v),
        .i_ex_we  (r_ex.we),
        .i_ex_rd  (r_ex.rd),
        .i_mem_v  (r_mem_v),
        .i_mem_we (r_mem_we),
        .i_mem_rd (r_mem_rd),
        .o_sel    (w_sel_a)
    );

    dlx_fwd_sel #(.RW(RW)) u_sel_b (
        .i_use    (i_id_valid & i_id_use2),
        .i_src    (i_id_rs2),
        .i_ex_v   (r_ex.v),
        .i_ex_we  (r_ex.we),
        .i_ex_rd  (r_ex.rd),
        .i_mem_v  (r_mem_v),
        .i_mem_we (r_mem_we),
        .i_mem_rd (r_mem_rd),
        .o_sel    (w_sel_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex        <= '0;
            r_mem_v     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_sa        <= SEL_RF;
            r_sb        <= SEL_RF;
            r_stall_cnt <= '0;
        end else if (!i_hold) begin
            r_mem_v  <= r_ex.v;
            r_mem_rd <= r_ex.rd;
            r_mem_we <= r_ex.we;
            if (w_haz) begin
                // Bubble into EX; the consumer retries from ID next cycle.
                r_ex <= '0;
                r_sa <= SEL_RF;
                r_sb <= SEL_RF;
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + CW'(1);
                end
            end else begin
                r_ex.v  <= i_id_valid;
                r_ex.rd <= i_id_rd;
                r_ex.we <= i_id_we & (i_id_rd != '0);
                r_ex.ld <= i_id_load;
                r_sa    <= w_sel_a;
                r_sb    <= w_sel_b;
            end
        end
    end

    assign o_sa0       = r_sa[0];
    assign o_sa1       = r_sa[1];
    assign o_sb0       = r_sb[0];
    assign o_sb1       = r_sb[1];
    assign o_haz_stall = w_haz;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dlx_fwd_ctrl.sv
// Directed bench for dlx_fwd_ctrl; a narrow-counter second instance shares the
// same stimulus so counter saturation is reachable in a short run.
module tb_dlx_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use1;
    logic       id_use2;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_load;

    logic        sa0, sa1, sb0, sb1, haz;
    logic [15:0] cnt;
    logic        t_sa0, t_sa1, t_sb0, t_sb1, t_haz;
    logic [2:0]  t_cnt;

    typedef struct {
        string      tag;
        logic [1:0] sa;
        logic [1:0] sb;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    dlx_fwd_ctrl #(.RW(5), .CW(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_id_rd(id_rd), .i_id_we(id_we), .i_id_load(id_load),
        .o_sa0(sa0), .o_sa1(sa1), .o_sb0(sb0), .o_sb1(sb1),
        .o_haz_stall(haz), .o_stall_cnt(cnt)
    );

    dlx_fwd_ctrl #(.RW(5), .CW(3)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_id_rd(id_rd), .i_id_we(id_we), .i_id_load(id_load),
        .o_sa0(t_sa0), .o_sa1(t_sa1), .o_sb0(t_sb0), .o_sb1(t_sb1),
        .o_haz_stall(t_haz), .o_stall_cnt(t_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic hd);
        id_valid = v;  id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
        id_rd = rd;    id_we = we;   id_load = ld; hold = hd;
    endtask

    // One ID presentation: checks the combinational stall now and the
    // registered selects/counter one edge later via the scoreboard.
    task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic hd, input logic eh,
                        input logic [1:0] esa, input logic [1:0] esb);
        exp_t e;
        int   sat;
        @(negedge clk);
        drive(v, rs1, u1, rs2, u2, rd, we, ld, hd);
        #1;
        chk({tag, ".haz"}, 16'(haz), 16'(eh));
        chk({tag, ".haz_n"}, 16'(t_haz), 16'(eh));
        if (eh && !hd) exp_cnt = exp_cnt + 1;
        sb_q.push_back('{tag, esa, esb, exp_cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        sat = (e.cnt > 7) ? 7 : e.cnt;
        chk({e.tag, ".sa"}, 16'({sa1, sa0}), 16'(e.sa));
        chk({e.tag, ".sb"}, 16'({sb1, sb0}), 16'(e.sb));
        chk({e.tag, ".cnt"}, cnt, 16'(e.cnt));
        chk({e.tag, ".sa_n"}, 16'({t_sa1, t_sa0}), 16'(e.sa));
        chk({e.tag, ".cnt_n"}, 16'(t_cnt), 16'(sat));
        $display("%-10s haz=%0b sa=%02b sb=%02b cnt=%0d cnt_n=%0d",
                 e.tag, haz, {sa1, sa0}, {sb1, sb0}, cnt, t_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sa", 16'({sa1, sa0}), 16'h0);
        chk("rst.sb", 16'({sb1, sb0}), 16'h0);
        chk("rst.haz", 16'(haz), 16'h0);
        chk("rst.cnt", cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //        tag         v rs1 u1 rs2 u2 rd we ld hd eh  sa     sb
        step("d1_add",   1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("d1_sub",   1, 3, 1, 5, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00);
        step("nop",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("d2_add",   1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("nop",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("d2_or",    1, 7, 1, 3, 1, 8, 1, 0, 0, 0, 2'b00, 2'b10);
        step("dp_add1",  1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("dp_add2",  1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("dp_and",   1, 3, 1, 3, 1, 9, 1, 0, 0, 0, 2'b01, 2'b01);
        step("lu_lw",    1, 1, 1, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00);
        step("lu_add",   1, 1, 1, 4, 1, 5, 1, 0, 0, 1, 2'b00, 2'b00);
        step("lu_retry", 1, 1, 1, 4, 1, 5, 1, 0, 0, 0, 2'b00, 2'b10);
        step("r0_add",   1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        step("r0_use",   1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00);
        step("h_add",    1, 1, 1, 2, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00);
        step("h_use",    1, 10, 1, 2, 1, 11, 1, 0, 0, 0, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step("hold",  1, 11, 1, 10, 1, 12, 1, 0, 1, 0, 2'b01, 2'b00);
        end
        step("h_resume", 1, 11, 1, 10, 1, 12, 1, 0, 0, 0, 2'b01, 2'b10);
        step("hl_lw",    1, 1, 1, 0, 0, 13, 1, 1, 0, 0, 2'b00, 2'b00);
        step("hl_held",  1, 13, 1, 0, 0, 14, 1, 0, 1, 1, 2'b00, 2'b00);
        step("hl_use",   1, 13, 1, 0, 0, 14, 1, 0, 0, 1, 2'b00, 2'b00);
        step("hl_retry", 1, 13, 1, 0, 0, 14, 1, 0, 0, 0, 2'b10, 2'b00);
        for (int i = 0; i < 6; i++) begin
            step("sat_lw",  1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00);
            step("sat_use", 1, 4, 1, 0, 0, 15, 1, 0, 0, 1, 2'b00, 2'b00);
        end
        step("rst_lw",   1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 2'b10, 2'b00);

        // Reset asserted while the stall request is live, between clock edges.
        @(negedge clk);
        drive(1, 0, 0, 4, 1, 5, 1, 0, 0);
        #1;
        chk("midrst.pre_haz", 16'(haz), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst.sa", 16'({sa1, sa0}), 16'h0);
        chk("midrst.sb", 16'({sb1, sb0}), 16'h0);
        chk("midrst.haz", 16'(haz), 16'h0);
        chk("midrst.cnt", cnt, 16'h0);
        chk("midrst.cnt_n", 16'(t_cnt), 16'h0);
        $display("midrst     haz=%0b sa=%02b sb=%02b cnt=%0d", haz, {sa1, sa0}, {sb1, sb0}, cnt);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_add", 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("post_use", 1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 2'b01, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlx_fwd_ctrl.md
Name: dlx_fwd_ctrl

Overview:
- Operand-bypass controller for the DLX integer pipeline.
- Tracks the destination register of the instructions in EX and MEM.
- Generates registered select pairs for the two 3-input operand muxes at the ALU inputs (A and B): IN0 = register-file operand, IN1 = EX/MEM result, IN2 = MEM/WB result.
- Detects load-use hazards, requests a one-cycle ID stall, and counts stall cycles.

Parameters:
- RW, 5, register-address width.
- CW, 16, stall-counter width.

Ports:
- CLK  input  1  pipeline clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- HOLD  input  1  global pipeline freeze (memory wait); all state holds.
- ID_VALID  input  1  ID-stage instruction valid.
- ID_RS1  input  RW  source register 1 of ID instruction.
- ID_RS2  input  RW  source register 2 of ID instruction.
- ID_USE1  input  1  ID instruction reads RS1.
- ID_USE2  input  1  ID instruction reads RS2.
- ID_RD  input  RW  destination register of ID instruction.
- ID_WE  input  1  ID instruction writes RD.
- ID_LOAD  input  1  ID instruction is a load.
- SA0  output  1  operand-A mux select bit 0, valid during EX.
- SA1  output  1  operand-A mux select bit 1.
- SB0  output  1  operand-B mux select bit 0.
- SB1  output  1  operand-B mux select bit 1.
- HAZ_STALL  output  1  load-use stall request to ID/IF (combinational).
- STALL_CNT  output  CW  saturating count of stall cycles.

Behaviour:
- Select encoding per mux:
  - {S1,S0} = 00 selects IN0 (register file).
  - 01 selects IN1 (EX/MEM).
  - 1x selects IN2 (MEM/WB); the controller always drives 10 for IN2, never 11.
- Internal state: EX slot {ex_v, ex_rd, ex_we, ex_ld} and MEM slot {mem_v, mem_rd, mem_we}.
- Write enable is captured as ID_WE & (ID_RD != 0). Register 0 is never a forwarding source.
- Load-use hazard: HAZ_STALL = ID_VALID & ex_v & ex_we & ex_ld & ((ID_USE1 & ID_RS1==ex_rd) | (ID_USE2 & ID_RS2==ex_rd)).
  - HAZ_STALL is combinational from the ID inputs and EX slot, with no internal delay.
- Per-source select for src in {RS1, RS2}, evaluated in ID:
  - If use & src != 0 & ex_v & ex_we & ex_rd==src: select 01.
  - Else if use & src != 0 & mem_v & mem_we & mem_rd==src: select 10.
  - Else: select 00.
  - Nearest producer wins when both slots match.
- Each rising CLK with RST_N=1:
  - HOLD=1: every register, select output and STALL_CNT unchanged. HOLD overrides HAZ_STALL; no count increment while held.
  - HOLD=0, HAZ_STALL=0: EX slot loads the ID fields (ex_v <= ID_VALID); MEM slot loads the EX slot; SA/SB load the computed selects.
  - HOLD=0, HAZ_STALL=1: bubble inserted (ex_v <= 0, SA/SB <= 00); MEM slot loads the EX slot; STALL_CNT increments and saturates at all-ones.
- Latency: selects are visible exactly one cycle after the consumer is presented in ID, aligned with that consumer's EX cycle.
- After a load stall the load sits in MEM, so the retried consumer gets select 10 (IN2).
- WB-stage producers need no forwarding; the register file is write-through in the same cycle.
- Invalid ID instructions (ID_VALID=0) produce selects 00 and no stall.
- Reset (RST_N low, any time, including mid-stall):
  - Immediately clears ex_v, mem_v, all rd/we/ld fields, SA0/SA1/SB0/SB1 = 0, and STALL_CNT = 0.
  - HAZ_STALL therefore reads 0.
  - First capture occurs on the first CLK edge after RST_N deasserts.

Decomposition:
- Package dlx_pipe_pkg holds:
  - RW default and the select encodings SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10.
  - The stage-slot record type {v, rd, we, ld}.
- One sub-module is natural: dlx_fwd_sel (combinational per-source comparator, instantiated twice, for A and B).
- Stage registers, hazard logic and counter stay in the top.

Test Plan:
- Reset mid-stream: RST_N pulled low while a load-use stall is active → SA/SB=00, HAZ_STALL=0, STALL_CNT=0 without waiting for a clock edge.
- Distance-1 ALU: ADD r3 (WE=1) then SUB with RS1=r3, USE1=1 → next cycle {SA1,SA0}=01, {SB1,SB0}=00, no stall.
- Distance-2 ALU: ADD r3, NOP, OR with RS2=r3 → {SB1,SB0}=10 in the OR's EX cycle.
- Double producer: ADD r3, ADD r3, AND with RS1=RS2=r3 → SA=01 and SB=01 (nearest wins).
- Load-use: LW r4 then ADD with RS2=r4:
  - HAZ_STALL=1 for exactly one cycle, then a bubble.
  - Retried ADD gets SB=10.
  - STALL_CNT 0→1.
  - Counter saturates at 16'hFFFF under repeated stalls.
- r0 and HOLD:
  - ADD r0 then use r0 → select 00.
  - HOLD=1 for 3 cycles during distance-1 forwarding → outputs frozen, forwarding resumes correctly after HOLD drops.
